// File: rtl/sync_tx_arbiter.sv
// sync_tx_arbiter: round-robin sequencer sharing one DataSync CDC channel between N requesters.
// Define SYNC_ARB_TIMEOUT_EN to bound the DRAIN wait and raise a sticky timeout_err.
module sync_tx_arbiter #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int IDW     = 2,
    parameter int GAP     = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*W-1:0]     req_data,
    output logic [N-1:0]       ack,
    output logic [W+IDW-1:0]   sync_data,
    output logic               sync_valid,
    input  logic               sync_busy,
    output logic [IDW-1:0]     active_id,
    output logic               timeout_err
);
    if (N < 2 || N > 8 || (2 ** IDW) < N || GAP < 0 || GAP > 255 || TIMEOUT < 1) begin : g_bad_param
        $error("sync_tx_arbiter: illegal parameter set");
    end
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_DRAIN, S_GAP} state_t;
    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, gnt_idx;
    logic           found, grant, tmo_hit;
    logic [7:0]     gap_cnt;
    // Descending scan so the requester closest after ptr wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[IDW'((int'(ptr) + k) % N)]) begin
                found   = 1'b1;
                gnt_idx = IDW'((int'(ptr) + k) % N);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            S_IDLE: begin
                grant     = found && !sync_busy;
                state_nxt = grant ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: state_nxt = S_ARM;
            S_ARM:   state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = (!sync_busy || tmo_hit) ? (GAP == 0 ? S_IDLE : S_GAP) : S_DRAIN;
            S_GAP:   state_nxt = (gap_cnt == 8'(GAP - 1)) ? S_IDLE : S_GAP;
            default: state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack        <= '0;
            sync_data  <= '0;
            sync_valid <= 1'b0;
            active_id  <= '0;
            ptr        <= IDW'(N - 1);
            gap_cnt    <= '0;
        end else begin
            ack        <= grant ? (N'(1) << gnt_idx) : '0;
            sync_valid <= (state == S_ISSUE);
            gap_cnt    <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
            if (grant) begin
                sync_data <= {gnt_idx, W'(req_data >> (int'(gnt_idx) * W))};
                active_id <= gnt_idx;
                ptr       <= gnt_idx;
            end
        end
    end
`ifdef SYNC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = (state == S_DRAIN) && (tmo_cnt == TW'(TIMEOUT - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == S_DRAIN) ? tmo_cnt + 1'b1 : '0;
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: doc/sync_tx_arbiter.md
Name: sync_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DataSync clock-domain-crossing channel between N requesters in the source (in_clk) domain.
- Accepts one word at a time. Tags each word with the requester index. Pulses the channel's valid input.
- Paces the next issue so that no word is dropped while the channel still holds data.
- Sits between the NeXT-side producers (e.g. keyboard/mouse/sound-command sources) and the DataSync in_data/in_data_valid pins.

Parameters:
- N, 4, number of requesters (2..8).
- W, 4, payload width per requester.
- IDW, 2, width of source tag; must satisfy 2**IDW >= N.
- GAP, 8, idle cycles enforced after the channel reports empty, before the next issue (0..255).
- TIMEOUT, 1024, max cycles spent waiting for the channel to empty (used only with SYNC_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  source-domain clock, identical to DataSync in_clk.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-requester request level; held high until the matching ack.
- req_data  in  N*W  packed payloads; requester i owns bits [i*W +: W].
- ack  out  N  one-cycle pulse; the payload of that requester was captured.
- sync_data  out  W+IDW  to DataSync in_data; {tag, payload}.
- sync_valid  out  1  to DataSync in_data_valid; one-cycle pulse.
- sync_busy  in  1  channel-occupied flag (DataSync has_data, in_clk domain).
- active_id  out  IDW  index of the last granted requester.
- timeout_err  out  1  sticky timeout flag; constant 0 without the macro.

Behaviour:
- Reset (asynchronous, active-high) values:
  - FSM = IDLE.
  - ack = 0, sync_valid = 0, sync_data = 0, active_id = 0, timeout_err = 0.
  - Round-robin pointer = N-1, so requester 0 has highest priority on the first grant.
- States: IDLE, ISSUE, ARM, DRAIN, GAP.
- IDLE:
  - If any req bit is high, grant the first requesting index found by scanning upward from (pointer+1) mod N, wrapping.
  - On grant, in the same cycle: register sync_data = {grant_idx[IDW-1:0], payload}, set active_id = grant_idx, set pointer = grant_idx, pulse ack[grant_idx] for one cycle. Next state is ISSUE.
  - If no req bit is high, stay in IDLE; all outputs hold.
- ISSUE:
  - sync_valid = 1 for exactly this cycle; sync_data is stable.
  - Next state is ARM.
- ARM:
  - One cycle. sync_busy is ignored, because DataSync raises has_data one cycle after valid.
  - Next state is DRAIN.
- DRAIN:
  - Wait until sync_busy = 0.
  - When sync_busy = 0: go to GAP, or to IDLE if GAP = 0.
- GAP:
  - Count GAP cycles, then go to IDLE.
  - A request present at the end of GAP is granted in the IDLE cycle that follows.
- Latency:
  - req high in IDLE -> ack in that cycle's registered output (cycle 1) -> sync_valid in cycle 2.
  - Minimum issue-to-issue spacing: 2 + (cycles sync_busy is high after ARM) + GAP + 1.
- sync_data holds its last value outside ISSUE. It is never changed while the FSM is in ISSUE, ARM or DRAIN.
- Requester rules:
  - req must stay high until ack.
  - Deasserting req before ack is legal; that requester is simply not granted.
  - req high in the cycle of its own ack counts as a new request, to be served after the other requesters.
- Simultaneous requests: exactly one ack per grant. No requester waits more than N-1 grants.
- sync_busy already high in IDLE (stale channel): no grant is made until it is low.
- Reset asserted mid-operation: the FSM aborts immediately and no further sync_valid is produced. A word already issued may still cross the channel.

Optional Feature:
- Macro: SYNC_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in DRAIN.
  - If sync_busy is still high after TIMEOUT cycles, set timeout_err = 1 (sticky until reset) and go to GAP as if the channel had drained.
  - Arbitration continues normally afterwards.
- Undefined:
  - DRAIN waits indefinitely.
  - timeout_err is tied to 0.
  - No counter logic is synthesized.

Test Plan:
- Single request: req = 4'b0100, req_data[11:8] = 4'hA, busy high 5 cycles after ARM, GAP = 8 -> ack[2] pulses once, sync_valid pulses one cycle later, sync_data = 6'b10_1010, no further valid for 5 + 8 cycles.
- All four requesting continuously with payloads 1,2,3,4 -> grant order 0,1,2,3,0; sync_data sequence 6'h01, 6'h12, 6'h23, 6'h34, 6'h01.
- Pointer wrap: last grant = 3, then req = 4'b1001 -> requester 0 is granted before 3.
- Busy stuck at 1 before any request, req = 4'b0001 -> no ack and no valid until busy falls; then ack[0] follows.
- Reset asserted in DRAIN with busy high -> all outputs 0 immediately; after release with req = 4'b0010 -> first grant is requester 1.
- With SYNC_ARB_TIMEOUT_EN, TIMEOUT = 16, busy stuck high -> timeout_err = 1 exactly 16 DRAIN cycles after ARM; the next request is still granted after GAP.
